// File: rtl/puf_soc_deser_pkg.sv
// puf_soc_pkg: shared definitions for the PUF SoC serial-to-parallel path.
//   IDLE / FILL / WAIT : controller state encodings
//   DEF_N_BIT          : default output word width
//   calc_cw()          : beat-counter width for a given beats-per-word count
package puf_soc_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int DEF_N_BIT = 32;

    // A single-beat word still needs a one-bit counter.
    function automatic int calc_cw(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/puf_soc_deser_if.sv
// puf_soc_deser_if: serial input stream and parallel output stream of the
// deserializer.
//   s_valid / s_ready / s_data [LANES]       : serial beats into the block
//   m_valid / m_ready / m_data [N_BIT], m_partial : words out of the block
//   modport slave  : the deserializer's view
//   modport master : the view of the surrounding logic (source and sink)
interface puf_soc_deser_if #(
    parameter int N_BIT = 32,
    parameter int LANES = 1
);
    logic             s_valid;
    logic             s_ready;
    logic [LANES-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [N_BIT-1:0] m_data;
    logic             m_partial;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_partial
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_partial
    );
endinterface

// File: rtl/puf_soc_deser_ctrl.sv
// puf_soc_deser_ctrl: sequencing for the deserializer.
//   Ports: clk, rst_n (async, active-low), i_clear, i_flush,
//          beat      - a serial beat is transferred this cycle
//          slot_free - output buffer empty or being emptied this cycle
//          cnt       - index of the next beat inside the word
//          s_ready   - state-decoded beat acceptance
//          load_out  - output buffer takes the fill word on the next edge
//                      (the fill register is zeroed on the same edge)
//          load_partial - m_partial value that goes with load_out
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no beats collected, cnt = 0
//   FILL  | 0 < cnt < BEATS, word under construction
//   WAIT  | fill register holds a finished word, output buffer still busy
module puf_soc_deser_ctrl
    import puf_soc_pkg::*;
#(
    parameter int BEATS = 32,
    parameter int CW    = calc_cw(BEATS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_flush,
    input  logic          beat,
    input  logic          slot_free,
    output logic [CW-1:0] cnt,
    output logic          s_ready,
    output logic          load_out,
    output logic          load_partial
);

    logic [1:0] state_q;
    logic       pend_partial_q;
    logic       last_beat;
    logic       complete;
    logic       flush_part;

    assign last_beat  = beat && (cnt == CW'(BEATS - 1));
    // A flush only means something once beats have been collected.
    assign complete   = last_beat || (i_flush && (state_q == FILL));
    assign flush_part = complete && !last_beat;

    assign s_ready = (state_q != WAIT);

    always_comb begin
        load_out     = 1'b0;
        load_partial = 1'b0;
        if (!i_clear) begin
            if (state_q == WAIT) begin
                load_out     = slot_free;
                load_partial = pend_partial_q;
            end else begin
                load_out     = complete && slot_free;
                load_partial = flush_part;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt            <= '0;
            pend_partial_q <= 1'b0;
        end else if (i_clear) begin
            state_q        <= IDLE;
            cnt            <= '0;
            pend_partial_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FILL: begin
                    if (complete) begin
                        if (slot_free) begin
                            state_q <= IDLE;
                            cnt     <= '0;
                        end else begin
                            state_q        <= WAIT;
                            pend_partial_q <= flush_part;
                        end
                    end else if (beat) begin
                        state_q <= FILL;
                        cnt     <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (slot_free) begin
                        state_q        <= IDLE;
                        cnt            <= '0;
                        pend_partial_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/puf_soc_deser.sv
// puf_soc_deser: LANES-bit serial beats in, N_BIT-bit words out, with a
// one-word output buffer so the next word fills while the current one waits.
//   Ports: clk, rst_n (async, active-low)
//          i_clear    - synchronous clear, drops partial and buffered words
//          i_flush    - emit the current partial word, zero padded
//          bus        - puf_soc_deser_if.slave (s_* beats, m_* words)
//          o_word_cnt - saturating count of delivered words, present only
//                       when PUF_SOC_DESER_WCNT_EN is defined
//   Parameters: N_BIT (multiple of LANES), LANES (1/2/4/8), MSB_FIRST.
//   The interface instance must be built with the same N_BIT and LANES.
module puf_soc_deser
    import puf_soc_pkg::*;
#(
    parameter int N_BIT     = DEF_N_BIT,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_flush,
    puf_soc_deser_if.slave bus
`ifdef PUF_SOC_DESER_WCNT_EN
    ,
    output logic [15:0] o_word_cnt
`endif
);

    localparam int BEATS = N_BIT / LANES;
    localparam int CW    = calc_cw(BEATS);

    logic [CW-1:0]    cnt;
    logic             s_ready;
    logic             beat;
    logic             slot_free;
    logic             load_out;
    logic             load_partial;
    logic [N_BIT-1:0] fill_q;
    logic [N_BIT-1:0] fill_next;
    logic [N_BIT-1:0] m_data_q;
    logic             m_valid_q;
    logic             m_partial_q;

    assign beat      = bus.s_valid && s_ready;
    assign slot_free = !m_valid_q || bus.m_ready;

    puf_soc_deser_ctrl #(
        .BEATS (BEATS),
        .CW    (CW)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (i_clear),
        .i_flush      (i_flush),
        .beat         (beat),
        .slot_free    (slot_free),
        .cnt          (cnt),
        .s_ready      (s_ready),
        .load_out     (load_out),
        .load_partial (load_partial)
    );

    // Beats land by index rather than by shifting, so a flushed word keeps
    // its received beats in their final positions and the rest stays zero.
    always_comb begin
        fill_next = fill_q;
        if (beat) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt == CW'(k)) begin
                    if (MSB_FIRST != 0) begin
                        fill_next[N_BIT - (k + 1) * LANES +: LANES] = bus.s_data;
                    end else begin
                        fill_next[k * LANES +: LANES] = bus.s_data;
                    end
                end
            end
        end
    end

    // fill_next already contains a beat arriving on the completing edge,
    // which is what gives the one-cycle last-beat-to-m_valid latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_partial_q <= 1'b0;
        end else if (i_clear) begin
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_partial_q <= 1'b0;
        end else begin
            if (load_out) begin
                fill_q      <= '0;
                m_data_q    <= fill_next;
                m_valid_q   <= 1'b1;
                m_partial_q <= load_partial;
            end else begin
                fill_q <= fill_next;
                if (bus.m_ready) begin
                    m_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_partial = m_partial_q;

`ifdef PUF_SOC_DESER_WCNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else if (i_clear) begin
            word_cnt_q <= '0;
        end else if (m_valid_q && bus.m_ready && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign o_word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_puf_soc_deser.sv
module tb_puf_soc_deser;

    typedef struct packed {
        logic [31:0] d;
        logic        p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr_a = 1'b0, fl_a = 1'b0;
    logic clr_b = 1'b0, fl_b = 1'b0;
    logic clr_c = 1'b0, fl_c = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    puf_soc_deser_if #(.N_BIT(8),  .LANES(1)) if_a ();
    puf_soc_deser_if #(.N_BIT(8),  .LANES(1)) if_b ();
    puf_soc_deser_if #(.N_BIT(32), .LANES(4)) if_c ();

`ifdef PUF_SOC_DESER_WCNT_EN
    logic [15:0] wc_a, wc_b, wc_c;
`endif

    puf_soc_deser #(.N_BIT(8), .LANES(1), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_clear(clr_a), .i_flush(fl_a), .bus(if_a)
`ifdef PUF_SOC_DESER_WCNT_EN
        , .o_word_cnt(wc_a)
`endif
    );

    puf_soc_deser #(.N_BIT(8), .LANES(1), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_clear(clr_b), .i_flush(fl_b), .bus(if_b)
`ifdef PUF_SOC_DESER_WCNT_EN
        , .o_word_cnt(wc_b)
`endif
    );

    puf_soc_deser #(.N_BIT(32), .LANES(4), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .i_clear(clr_c), .i_flush(fl_c), .bus(if_c)
`ifdef PUF_SOC_DESER_WCNT_EN
        , .o_word_cnt(wc_c)
`endif
    );

    // ---------------- scoreboard monitors (sample on negedge) ----------------
    exp_t e_a, e_b, e_c;
    logic       hv_a = 1'b0, hv_b = 1'b0, hv_c = 1'b0;
    logic [8:0]  hd_a, hd_b;
    logic [32:0] hd_c;

    always @(negedge clk) begin
        if (rst_n && if_a.m_valid) begin
            if (hv_a) begin
                n_total++;
                if ({if_a.m_data, if_a.m_partial} !== hd_a)
                    $display("FAIL a_stable got %h want %h", {if_a.m_data, if_a.m_partial}, hd_a);
                else n_pass++;
            end
            if (if_a.m_ready) begin
                n_total++;
                if (q_a.size() == 0) begin
                    $display("FAIL a_unexpected got data %h partial %b", if_a.m_data, if_a.m_partial);
                end else begin
                    e_a = q_a.pop_front();
                    if ({if_a.m_data, if_a.m_partial} !== {e_a.d[7:0], e_a.p})
                        $display("FAIL a_word got %h/%b want %h/%b", if_a.m_data, if_a.m_partial, e_a.d[7:0], e_a.p);
                    else n_pass++;
                end
            end
        end
        hv_a = rst_n && if_a.m_valid && !if_a.m_ready;
        hd_a = {if_a.m_data, if_a.m_partial};
    end

    always @(negedge clk) begin
        if (rst_n && if_b.m_valid) begin
            if (hv_b) begin
                n_total++;
                if ({if_b.m_data, if_b.m_partial} !== hd_b)
                    $display("FAIL b_stable got %h want %h", {if_b.m_data, if_b.m_partial}, hd_b);
                else n_pass++;
            end
            if (if_b.m_ready) begin
                n_total++;
                if (q_b.size() == 0) begin
                    $display("FAIL b_unexpected got data %h partial %b", if_b.m_data, if_b.m_partial);
                end else begin
                    e_b = q_b.pop_front();
                    if ({if_b.m_data, if_b.m_partial} !== {e_b.d[7:0], e_b.p})
                        $display("FAIL b_word got %h/%b want %h/%b", if_b.m_data, if_b.m_partial, e_b.d[7:0], e_b.p);
                    else n_pass++;
                end
            end
        end
        hv_b = rst_n && if_b.m_valid && !if_b.m_ready;
        hd_b = {if_b.m_data, if_b.m_partial};
    end

    always @(negedge clk) begin
        if (rst_n && if_c.m_valid) begin
            if (hv_c) begin
                n_total++;
                if ({if_c.m_data, if_c.m_partial} !== hd_c)
                    $display("FAIL c_stable got %h want %h", {if_c.m_data, if_c.m_partial}, hd_c);
                else n_pass++;
            end
            if (if_c.m_ready) begin
                n_total++;
                if (q_c.size() == 0) begin
                    $display("FAIL c_unexpected got data %h partial %b", if_c.m_data, if_c.m_partial);
                end else begin
                    e_c = q_c.pop_front();
                    if ({if_c.m_data, if_c.m_partial} !== {e_c.d, e_c.p})
                        $display("FAIL c_word got %h/%b want %h/%b", if_c.m_data, if_c.m_partial, e_c.d, e_c.p);
                    else n_pass++;
                end
            end
        end
        hv_c = rst_n && if_c.m_valid && !if_c.m_ready;
        hd_c = {if_c.m_data, if_c.m_partial};
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = {24'h0, d};
        e.p = p;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = {24'h0, d};
        e.p = p;
        q_b.push_back(e);
    endtask

    task automatic push_c(input logic [31:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        q_c.push_back(e);
    endtask

    // Sends an 8-bit word to dut_a LSB-first, honouring s_ready.
    task automatic send_a(input logic [7:0] w, input bit push);
        bit acc;
        int guard;
        if (push) push_a(w, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if_a.s_valid = 1'b1;
            if_a.s_data  = w[k];
            guard = 0;
            do begin
                acc = if_a.s_ready;
                tick();
                guard++;
            end while (!acc && guard < 200);
            if (!acc) begin
                n_total++;
                $display("FAIL a_beat_timeout beat %0d s_ready %b want 1", k, if_a.s_ready);
            end
        end
        if_a.s_valid = 1'b0;
    endtask

    // One nibble beat to dut_c, optionally with i_flush in the same cycle.
    task automatic send_c(input logic [3:0] nib, input logic flush);
        bit acc;
        int guard;
        if_c.s_valid = 1'b1;
        if_c.s_data  = nib;
        fl_c         = flush;
        guard = 0;
        do begin
            acc = if_c.s_ready;
            tick();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) begin
            n_total++;
            $display("FAIL c_beat_timeout s_ready %b want 1", if_c.s_ready);
        end
        if_c.s_valid = 1'b0;
        fl_c         = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        n_total++;
        if ({if_a.s_ready, if_a.m_valid, if_a.m_data, if_a.m_partial} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_a got rdy %b vld %b data %h part %b want 1 0 00 0",
                     if_a.s_ready, if_a.m_valid, if_a.m_data, if_a.m_partial);
        else n_pass++;
        n_total++;
        if ({if_c.s_ready, if_c.m_valid, if_c.m_data, if_c.m_partial} !== {1'b1, 1'b0, 32'h0, 1'b0})
            $display("FAIL reset_c got rdy %b vld %b data %h part %b want 1 0 0 0",
                     if_c.s_ready, if_c.m_valid, if_c.m_data, if_c.m_partial);
        else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({if_b.s_ready, if_b.m_valid} !== 2'b10)
            $display("FAIL reset_b_release got rdy %b vld %b want 1 0", if_b.s_ready, if_b.m_valid);
        else n_pass++;
    endtask

    task automatic test_bit_order();
        logic [7:0] bits;
        logic       exp_v;
        bits = 8'b0100_1101;   // beat k carries bits[k]: 1,0,1,1,0,0,1,0
        push_a(8'h4D, 1'b0);
        push_b(8'hB2, 1'b0);
        if_a.m_ready = 1'b1;
        if_b.m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if_a.s_valid = 1'b1; if_a.s_data = bits[k];
            if_b.s_valid = 1'b1; if_b.s_data = bits[k];
            tick();
            exp_v = (k == 7);
            n_total++;
            if (if_a.m_valid !== exp_v)
                $display("FAIL order_latency beat %0d m_valid %b want %b", k, if_a.m_valid, exp_v);
            else n_pass++;
        end
        if_a.s_valid = 1'b0;
        if_b.s_valid = 1'b0;
        tick();
        n_total++;
        if ({if_a.m_valid, if_b.m_valid} !== 2'b00)
            $display("FAIL order_one_cycle m_valid a %b b %b want 0 0", if_a.m_valid, if_b.m_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        if_c.m_ready = 1'b1;
        push_c(32'h87654321, 1'b0);
        for (int n = 1; n <= 8; n++) send_c(4'(n), 1'b0);
        push_c(32'h00000CBA, 1'b1);
        send_c(4'hA, 1'b0);
        send_c(4'hB, 1'b0);
        send_c(4'hC, 1'b0);
        fl_c = 1'b1;
        tick();
        fl_c = 1'b0;
        n_total++;
        if ({if_c.m_valid, if_c.m_partial} !== 2'b11)
            $display("FAIL flush_latency m_valid %b m_partial %b want 1 1", if_c.m_valid, if_c.m_partial);
        else n_pass++;
        // flush together with the completing beat: full word, not partial
        push_c(32'h23456789, 1'b0);
        for (int n = 9; n >= 3; n--) send_c(4'(n), 1'b0);
        send_c(4'h2, 1'b1);
        // flush together with a middle beat: that beat is kept
        push_c(32'h00000FED, 1'b1);
        send_c(4'hD, 1'b0);
        send_c(4'hE, 1'b0);
        send_c(4'hF, 1'b1);
        repeat (2) tick();
        // flush in IDLE produces nothing
        fl_c = 1'b1;
        tick();
        fl_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (if_c.m_valid !== 1'b0)
                $display("FAIL flush_idle_c cycle %0d m_valid %b want 0", i, if_c.m_valid);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        if_a.m_ready = 1'b0;
        send_a(8'h5A, 1'b1);
        send_a(8'hC3, 1'b1);
        n_total++;
        if ({if_a.s_ready, if_a.m_valid, if_a.m_data} !== {1'b0, 1'b1, 8'h5A})
            $display("FAIL b2b_wait got rdy %b vld %b data %h want 0 1 5a",
                     if_a.s_ready, if_a.m_valid, if_a.m_data);
        else n_pass++;
        fork
            send_a(8'h96, 1'b1);
            begin
                fl_a = 1'b1;   // must be ignored while waiting
                for (int i = 0; i < 3; i++) begin
                    tick();
                    fl_a = 1'b0;
                    n_total++;
                    if (if_a.s_ready !== 1'b0)
                        $display("FAIL b2b_hold cycle %0d s_ready %b want 0", i, if_a.s_ready);
                    else n_pass++;
                end
                if_a.m_ready = 1'b1;
                tick();
                n_total++;
                if ({if_a.m_valid, if_a.m_data, if_a.m_partial} !== {1'b1, 8'hC3, 1'b0})
                    $display("FAIL b2b_second got vld %b data %h part %b want 1 c3 0",
                             if_a.m_valid, if_a.m_data, if_a.m_partial);
                else n_pass++;
            end
        join
        repeat (3) tick();
    endtask

    task automatic test_clear();
        logic [4:0] junk;
        junk = 5'b10101;
        if_a.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if_a.s_valid = 1'b1;
            if_a.s_data  = junk[k];
            tick();
        end
        if_a.s_valid = 1'b0;
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_total++;
        if ({if_a.s_ready, if_a.m_valid} !== 2'b10)
            $display("FAIL clear_state got rdy %b vld %b want 1 0", if_a.s_ready, if_a.m_valid);
        else n_pass++;
        send_a(8'hFF, 1'b1);
        repeat (2) tick();
        // clear drops a buffered word that was never taken
        if_a.m_ready = 1'b0;
        send_a(8'h11, 1'b0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        n_total++;
        if ({if_a.m_valid, if_a.m_data} !== {1'b0, 8'h00})
            $display("FAIL clear_buffer got vld %b data %h want 0 00", if_a.m_valid, if_a.m_data);
        else n_pass++;
        if_a.m_ready = 1'b1;
        fl_a = 1'b1;
        tick();
        fl_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (if_a.m_valid !== 1'b0)
                $display("FAIL flush_idle_a cycle %0d m_valid %b want 0", i, if_a.m_valid);
            else n_pass++;
        end
    endtask

`ifdef PUF_SOC_DESER_WCNT_EN
    task automatic test_word_cnt();
        clr_c = 1'b1;
        tick();
        clr_c = 1'b0;
        n_total++;
        if (wc_c !== 16'd0)
            $display("FAIL wcnt_clear got %0d want 0", wc_c);
        else n_pass++;
        if_c.m_ready = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            push_c({8{4'(w)}}, 1'b0);
            for (int k = 0; k < 8; k++) send_c(4'(w), 1'b0);
        end
        repeat (2) tick();
        n_total++;
        if (wc_c !== 16'd3)
            $display("FAIL wcnt_three got %0d want 3", wc_c);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        if_a.m_ready = 1'b0;
        send_a(8'h3C, 1'b0);
        send_c(4'h7, 1'b0);
        send_c(4'h6, 1'b0);
        send_c(4'h5, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if ({if_a.s_ready, if_a.m_valid, if_a.m_data, if_a.m_partial} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL async_reset_a got rdy %b vld %b data %h part %b want 1 0 00 0",
                     if_a.s_ready, if_a.m_valid, if_a.m_data, if_a.m_partial);
        else n_pass++;
`ifdef PUF_SOC_DESER_WCNT_EN
        n_total++;
        if ({wc_a, wc_c} !== 32'h0)
            $display("FAIL async_reset_wcnt got a %0d c %0d want 0 0", wc_a, wc_c);
        else n_pass++;
`endif
        tick();
        rst_n = 1'b1;
        if_a.m_ready = 1'b1;
        if_c.m_ready = 1'b1;
        tick();
        send_a(8'h81, 1'b1);
        push_c(32'hA5A5A5A5, 1'b0);
        for (int k = 0; k < 8; k++) send_c((k % 2 == 0) ? 4'h5 : 4'hA, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        if_a.s_valid = 1'b0; if_a.s_data = '0; if_a.m_ready = 1'b1;
        if_b.s_valid = 1'b0; if_b.s_data = '0; if_b.m_ready = 1'b1;
        if_c.s_valid = 1'b0; if_c.s_data = '0; if_c.m_ready = 1'b1;
        test_reset();
        test_bit_order();
        test_flush();
        test_back_to_back();
        test_clear();
`ifdef PUF_SOC_DESER_WCNT_EN
        test_word_cnt();
`endif
        test_async_reset();
        n_total++;
        if (q_a.size() != 0) $display("FAIL drain_a left %0d want 0", q_a.size());
        else n_pass++;
        n_total++;
        if (q_b.size() != 0) $display("FAIL drain_b left %0d want 0", q_b.size());
        else n_pass++;
        n_total++;
        if (q_c.size() != 0) $display("FAIL drain_c left %0d want 0", q_c.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/puf_soc_deser.md
Name: puf_soc_deser

Overview:
Parametrised serial-to-parallel deserializer. It is the next-generation SIPO for the PUF SoC challenge/response path.
- Collects LANES bits per beat over a valid/ready stream and emits N_BIT-bit words on a valid/ready output.
- A one-word output buffer lets the next word fill while the current one is held.
- Adds selectable bit order, flush of partial words with zero padding, and synchronous clear.
- Sits between the serial host/UART front end and the PUF challenge register / response FIFO.

Parameters:
- N_BIT, 32: output word width; must be a multiple of LANES.
- LANES, 1: serial bits accepted per beat (1, 2, 4 or 8).
- MSB_FIRST, 0: 0 = first beat lands in the LSBs; 1 = first beat lands in the MSBs.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_clear  in  1  synchronous clear; drops partial and buffered words
- i_flush  in  1  emit the current partial word, zero-padded
- s_valid  in  1  serial beat valid
- s_ready  out  1  deserializer can accept a beat
- s_data  in  LANES  serial beat data
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  N_BIT  output word
- m_partial  out  1  qualifies m_data: word was produced by flush (unreceived beats are zero)

Behaviour:
- Derived constants: BEATS = N_BIT/LANES; beat counter width CW = max(1, $clog2(BEATS)).
- Beat placement: beat k (0-based) is written into a fill register by index, not by shift.
  - MSB_FIRST=0: bits [k*LANES +: LANES].
  - MSB_FIRST=1: bits [N_BIT-1-k*LANES -: LANES].
  - Unwritten positions are 0; the fill register is zeroed each time a word leaves it.
- Reset values: state IDLE, cnt 0, fill reg 0, s_ready 1, m_valid 0, m_data 0, m_partial 0.
- Handshakes:
  - Beat transfer when s_valid & s_ready.
  - Word transfer when m_valid & m_ready.
  - m_data/m_partial stay stable while m_valid & !m_ready.
  - m_valid never drops without a transfer (except on i_clear).
  - s_ready is purely state-decoded: s_ready = (state != WAIT). There is no combinational path from m_ready.
- Slot free = !m_valid | m_ready.
- FSM states:
  - IDLE: cnt = 0, no partial data.
  - FILL: 0 < cnt < BEATS.
  - WAIT: fill reg holds a complete or flushed word, but the output buffer is occupied.
- Completion event: the last beat is accepted (cnt == BEATS-1), or i_flush is asserted in FILL.
  - If the slot is free: load the output buffer next edge. m_valid=1 one cycle after the completing beat. m_partial = flush & !last-beat. cnt→0, state→IDLE.
  - If the slot is busy: →WAIT, cnt held, pending-partial flag stored.
- WAIT: on word transfer, the fill reg moves to the output buffer on the same edge (m_valid stays 1); →IDLE.
- Latency: last beat to m_valid = 1 cycle. Sustained throughput is one word per BEATS cycles with m_ready held high.
- i_flush boundary conditions:
  - Ignored in IDLE; no empty words are emitted.
  - Ignored in WAIT.
  - With a simultaneous beat: the beat is included first. If that beat completes the word, m_partial=0.
- i_clear: highest priority. Next edge: state IDLE, cnt 0, fill reg 0, m_valid 0, m_partial 0. A word being transferred the same cycle is considered delivered.
- rst_n mid-word: asynchronous return to reset values; the partial word is lost.
- Beats with s_ready=0 are not consumed; the source must hold them.

Optional Feature:
- Macro: PUF_SOC_DESER_WCNT_EN.
- Defined: adds output o_word_cnt [15:0].
  - Increments on every word transfer; saturates at 16'hFFFF.
  - Cleared by rst_n and i_clear.
  - Counts flushed words too.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package puf_soc_pkg: state encoding localparams (IDLE=2'd0, FILL=2'd1, WAIT=2'd2), default word width constant, helper for CW.
- One sub-module, puf_soc_deser_ctrl: FSM, beat counter, pending-partial flag, load/clear strobes.
- Top level holds the fill register, index write and output buffer.

Test Plan:
- N_BIT=8, LANES=1, MSB_FIRST=0; beats 1,0,1,1,0,0,1,0 with m_ready=1 → m_data=8'h4D, m_partial=0, m_valid high exactly 1 cycle after the 8th beat.
- Same stream with MSB_FIRST=1 → m_data=8'hB2.
- N_BIT=32, LANES=4; nibbles 1..8, then 3 nibbles A,B,C + i_flush, m_ready=1 → first word 32'h87654321 m_partial=0; second 32'h00000CBA m_partial=1.
- Hold m_ready=0 across two full words → s_ready drops after the second word's last beat (WAIT); raising m_ready gives back-to-back m_valid with both words in order and no beat lost.
- i_clear mid-word after 5 beats, then 8 fresh beats 8'hFF → only 8'hFF is emitted; i_flush in IDLE emits nothing.
- With PUF_SOC_DESER_WCNT_EN: deliver 3 words → o_word_cnt=3; assert rst_n low mid-word → all outputs return to reset values asynchronously.
